hamming_req_scheduler: RTL and testbench
========================================

// Module: hamming_req_scheduler
// PURPOSE
//  Shares one Hamming(15,11) chain (calcula_hamming -> injetor -> corrige_hamming) between two requesters, A and B.
//  Round-robin arbitration. Each accepted request is encoded, optionally hit with an injected error, then corrected.
//  Registered stages; one request in flight at a time. The result returns on a single response port with the requester id.
//  Sits above the combinational Hamming modules and replaces testbench-driven sequencing in the system.
// PARAMETERS
//  CNT_W    8  width of the corrected-request counter (ERR_COUNT_EN only)
//  RR_EN    1  1 = round-robin arbitration; 0 = fixed priority, A always wins
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   synchronous reset, active-low
//  a_valid        in   1   requester A has a request
//  a_ready        out  1   A request accepted this cycle when a_valid&&a_ready
//  a_data         in   11  A data word
//  a_n            in   4   A error bit position, passed to injetor n
//  a_err          in   1   A inject-error enable
//  b_valid/b_ready/b_data/b_n/b_err  same as A, for requester B
//  resp_valid     out  1   response available
//  resp_ready     in   1   consumer accepts response
//  resp_id        out  1   0 = A, 1 = B
//  resp_data      out  11  corrected data out of corrige_hamming
//  resp_code      out  15  codeword as encoded, before injection
//  resp_mismatch  out  1   resp_data != original request data
//  busy           out  1   state != IDLE
//  err_count      out  CNT_W  number of responses with err applied (ERR_COUNT_EN only)
// BEHAVIOUR
//  - Synchronous reset (rst_n==0 at posedge):
//    - state=IDLE
//    - all outputs 0 (a_ready, b_ready, resp_*, busy, err_count)
//    - rr pointer set so that A wins the first tie
//    - any in-flight request is discarded
//  - FSM states: IDLE -> ENC -> COR -> RESP -> IDLE.
//  - IDLE:
//    - x_ready is asserted combinationally only for the arbitration winner; at most one ready is high per cycle.
//    - No valid -> both ready low.
//    - Handshake latches data, n, err and id, then moves to ENC.
//  - Arbitration:
//    - One valid -> that requester wins.
//    - Both valid with RR_EN=1 -> the requester not granted last wins. The pointer updates only on a handshake.
//  - ENC: register the calcula_hamming output into resp_code; go to COR.
//  - COR:
//    - Drive injetor with the latched n and err; register the corrige_hamming output into resp_data.
//    - resp_mismatch = (resp_data != latched data).
//    - Go to RESP.
//  - Injection guard: if n==4'd15, the erro input to injetor is forced to 0 (no valid bit position).
//  - RESP:
//    - resp_valid=1, with resp_* held stable until resp_valid&&resp_ready.
//    - On that handshake: resp_valid=0 next cycle, state=IDLE.
//  - Latency: request handshake at cycle T -> resp_valid high at T+3 at the earliest. Next accept is no earlier than one cycle after the response handshake.
//  - Backpressure: resp_ready low keeps the block in RESP indefinitely; both x_ready stay low.
//  - Requester inputs are ignored outside IDLE. A requester may drop valid before it is granted, with no effect.
// CONFIGURATION
//  - Macro HAMMING_SCHED_ERR_COUNT_EN.
//  - Defined:
//    - err_count port exists.
//    - It increments by 1 on each response handshake whose effective err was 1 (after the n==15 guard).
//    - It saturates at 2^CNT_W-1 and resets to 0.
//  - Undefined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles mid-COR -> next cycle busy=0, resp_valid=0, ready low; the prior request yields no response.
//  2. Single A request: data=11'h5A3, err=0 -> resp_valid at T+3, resp_id=0, resp_data=11'h5A3, resp_mismatch=0.
//  3. Error sweep: B, data=11'h2C7, err=1, n=0..14 -> resp_data=11'h2C7 and resp_mismatch=0 for every n. n=15 also returns 11'h2C7, and counter+0.
//  4. Contention: A and B valid every cycle, RR_EN=1 -> grants A,B,A,B. With RR_EN=0 -> grants are all A.
//  5. Backpressure: resp_ready=0 for 10 cycles -> resp_* stable, both ready=0. resp_ready=1 -> IDLE next cycle.
//  6. ERR_COUNT_EN with CNT_W=2: 5 requests with err=1, n=3 -> err_count 1,2,3,3,3.

Source files
------------

// File: rtl/hamming_req_scheduler.sv
// hamming_req_scheduler
//   Shares one Hamming(15,11) chain (encode -> inject -> correct) between two
//   requesters A and B. One request is in flight at a time. It is encoded in
//   ENC, injected and corrected in COR, and presented on the response port in
//   RESP until the consumer accepts it.
//   Optional feature: define HAMMING_SCHED_ERR_COUNT_EN to add the err_count
//   port, which counts responses whose effective inject-error was set.
//   Codeword layout: bit i holds Hamming position i+1. Parity sits at positions
//   1,2,4,8. Data bits fill positions 3,5,6,7,9..15 in ascending order.
module hamming_req_scheduler #(
   parameter int CNT_W = 8,
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [10:0] a_data,
   input  logic [3:0]  a_n,
   input  logic        a_err,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [10:0] b_data,
   input  logic [3:0]  b_n,
   input  logic        b_err,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [10:0] resp_data,
   output logic [14:0] resp_code,
   output logic        resp_mismatch,
   output logic        busy
`ifdef HAMMING_SCHED_ERR_COUNT_EN
   ,
   output logic [CNT_W-1:0] err_count
`endif
);

   typedef enum logic [1:0] {IDLE, ENC, COR, RESP} state_t;

   // Syndrome masks: mask k covers every position whose index has bit k set.
   localparam logic [14:0] MASK0 = 15'h5555;
   localparam logic [14:0] MASK1 = 15'h6666;
   localparam logic [14:0] MASK2 = 15'h7878;
   localparam logic [14:0] MASK3 = 15'h7F80;

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   // Encoder: place the data bits, then set each parity bit to make its group even.
   function automatic logic [14:0] calcula_hamming(input logic [10:0] d);
      logic [14:0] c;
      c        = '0;
      c[2]     = d[0];
      c[6:4]   = d[3:1];
      c[14:8]  = d[10:4];
      c[0]     = ^(c & MASK0);
      c[1]     = ^(c & MASK1);
      c[3]     = ^(c & MASK2);
      c[7]     = ^(c & MASK3);
      return c;
   endfunction

   // Injector: flip codeword bit n when erro is set.
   function automatic logic [14:0] injetor(input logic [14:0] c, input logic [3:0] n,
                                           input logic erro);
      return erro ? (c ^ (15'd1 << n)) : c;
   endfunction

   // Corrector: a non-zero syndrome names the faulty position; flip it and extract data.
   function automatic logic [10:0] corrige_hamming(input logic [14:0] r);
      logic [3:0]  s;
      logic [14:0] fixed;
      s     = {^(r & MASK3), ^(r & MASK2), ^(r & MASK1), ^(r & MASK0)};
      fixed = (s != 4'd0) ? (r ^ (15'd1 << (s - 4'd1))) : r;
      return {fixed[14:8], fixed[6:4], fixed[2]};
   endfunction

   state_t      state, state_nx;
   logic        grant_a, grant_b;
   logic        last_grant;   // 0 = A was granted last, 1 = B
   logic [10:0] lat_data;
   logic [3:0]  lat_n;
   logic        lat_err;      // effective error enable, n==15 already masked
   logic [14:0] enc_code;
   logic [10:0] cor_data;
   logic        a_hs, b_hs;

   assign a_hs = a_valid && a_ready;
   assign b_hs = b_valid && b_ready;

   // Arbitration: a lone requester wins; on a tie, round-robin or fixed A priority.
   always_comb begin
      grant_a = a_valid && (!b_valid || !RR_EN || last_grant);
      grant_b = b_valid && !grant_a;
   end

   // Hamming chain fed from the latched request and the registered codeword.
   always_comb begin
      enc_code = calcula_hamming(lat_data);
      cor_data = corrige_hamming(injetor(resp_code, lat_n, lat_err));
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create order-dependent races.
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default first so every path assigns state_nx and no latch is inferred.
      state_nx = state;
      case (state)
         IDLE:    if (a_hs || b_hs) state_nx = ENC;
         ENC:     state_nx = COR;
         COR:     state_nx = RESP;
         RESP:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs: ready only for the winner in IDLE, held low while reset is asserted.
   always_comb begin
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      busy       = (state != IDLE);
      resp_valid = (state == RESP);
      if (state == IDLE && rst_n) begin
         a_ready = grant_a;
         b_ready = grant_b;
      end
   end

   // Datapath: latch the request, register the codeword, then the corrected word.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant    <= 1'b1;
         lat_data      <= '0;
         lat_n         <= '0;
         lat_err       <= 1'b0;
         resp_id       <= 1'b0;
         resp_code     <= '0;
         resp_data     <= '0;
         resp_mismatch <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (a_hs) begin
                  last_grant <= 1'b0;
                  resp_id    <= 1'b0;
                  lat_data   <= a_data;
                  lat_n      <= a_n;
                  lat_err    <= a_err && (a_n != 4'd15);
               end else if (b_hs) begin
                  last_grant <= 1'b1;
                  resp_id    <= 1'b1;
                  lat_data   <= b_data;
                  lat_n      <= b_n;
                  lat_err    <= b_err && (b_n != 4'd15);
               end
            end
            ENC: resp_code <= enc_code;
            COR: begin
               resp_data     <= cor_data;
               resp_mismatch <= (cor_data != lat_data);
            end
            default: ;
         endcase
      end
   end

`ifdef HAMMING_SCHED_ERR_COUNT_EN
   // Saturating count of accepted responses that carried an effective error.
   always_ff @(posedge clk) begin
      if (!rst_n)
         err_count <= '0;
      else if (state == RESP && resp_ready && lat_err && (err_count != {CNT_W{1'b1}}))
         err_count <= err_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_hamming_req_scheduler.sv
// Testbench for hamming_req_scheduler: scoreboard of expected responses pushed
// when a request handshake is seen and popped on the response handshake.
// A round-robin instance and a fixed-priority instance run on the same inputs.
module tb_hamming_req_scheduler;
   localparam int CNT_W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 0, b_valid = 0, a_err = 0, b_err = 0, resp_ready = 1;
   logic [10:0] a_data = '0, b_data = '0;
   logic [3:0]  a_n = '0, b_n = '0;

   logic        a_ready, b_ready, resp_valid, resp_id, resp_mismatch, busy;
   logic [10:0] resp_data;
   logic [14:0] resp_code;
   logic        fp_a_ready, fp_b_ready, fp_resp_valid, fp_resp_id, fp_resp_mismatch, fp_busy;
   logic [10:0] fp_resp_data;
   logic [14:0] fp_resp_code;
`ifdef HAMMING_SCHED_ERR_COUNT_EN
   logic [CNT_W-1:0] err_count, fp_err_count;
`endif

   always #5 clk = ~clk;

   hamming_req_scheduler #(.CNT_W(CNT_W), .RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_n(a_n), .a_err(a_err),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_n(b_n), .b_err(b_err),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .resp_code(resp_code), .resp_mismatch(resp_mismatch),
      .busy(busy)
`ifdef HAMMING_SCHED_ERR_COUNT_EN
      , .err_count(err_count)
`endif
   );

   hamming_req_scheduler #(.CNT_W(CNT_W), .RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(fp_a_ready), .a_data(a_data), .a_n(a_n), .a_err(a_err),
      .b_valid(b_valid), .b_ready(fp_b_ready), .b_data(b_data), .b_n(b_n), .b_err(b_err),
      .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id),
      .resp_data(fp_resp_data), .resp_code(fp_resp_code), .resp_mismatch(fp_resp_mismatch),
      .busy(fp_busy)
`ifdef HAMMING_SCHED_ERR_COUNT_EN
      , .err_count(fp_err_count)
`endif
   );

   typedef struct {
      logic        id;
      logic [10:0] data;
      logic        eff_err;
      logic        fp_id;
      logic [10:0] fp_data;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   logic grants[$];
   int   tests = 0, fails = 0;
   int   cyc = 0;
   bit   m_idle = 1, m_last = 1, lat_seen = 0, rec_grants = 0;
   int   m_cnt = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Syndrome from the parity-check definition: XOR of positions of set bits.
   function automatic logic [3:0] syndrome(input logic [14:0] c);
      logic [3:0] s = '0;
      for (int i = 0; i < 15; i++) if (c[i]) s ^= 4'(i + 1);
      return s;
   endfunction

   // Data bits occupy the non-power-of-two positions in ascending order.
   function automatic logic [10:0] extract(input logic [14:0] c);
      logic [10:0] d = '0;
      int k = 0;
      for (int p = 1; p <= 15; p++)
         if ((p & (p - 1)) != 0) begin
            d[k] = c[p-1];
            k++;
         end
      return d;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / reference model, sampled on the falling edge.
   always @(negedge clk) begin
      logic ea, eb;
      exp_t e, h;
      if (!rst_n) begin
         sb.delete();
         m_idle = 1; m_last = 1; m_cnt = 0; lat_seen = 0;
         check("ready_in_reset", {a_ready, b_ready}, 0);
      end else begin
`ifdef HAMMING_SCHED_ERR_COUNT_EN
         check("err_count", err_count, m_cnt);
`endif
         if (m_idle) begin
            ea = a_valid && (!b_valid || m_last);
            eb = b_valid && !ea;
            check("a_ready", a_ready, ea);
            check("b_ready", b_ready, eb);
            check("busy_idle", busy, 0);
            check("resp_valid_idle", resp_valid, 0);
            if (ea || eb) begin
               e.id      = eb;
               e.data    = eb ? b_data : a_data;
               e.eff_err = eb ? (b_err && b_n != 4'd15) : (a_err && a_n != 4'd15);
               e.fp_id   = !a_valid;
               e.fp_data = a_valid ? a_data : b_data;
               e.acc_cyc = cyc;
               sb.push_back(e);
               m_idle   = 0;
               m_last   = eb;
               lat_seen = 0;
               if (rec_grants) grants.push_back(eb);
            end
         end else begin
            check("ready_busy", {a_ready, b_ready}, 0);
            check("busy_active", busy, 1);
            if (resp_valid) begin
               if (sb.size() == 0) begin
                  check("resp_unexpected", resp_valid, 0);
               end else begin
                  h = sb[0];
                  if (!lat_seen) begin
                     check("latency", cyc - h.acc_cyc, 3);
                     lat_seen = 1;
                  end
                  check("resp_id", resp_id, h.id);
                  check("resp_data", resp_data, h.data);
                  check("resp_mismatch", resp_mismatch, 0);
                  check("code_syndrome", syndrome(resp_code), 0);
                  check("code_data", extract(resp_code), h.data);
                  if (resp_ready) begin
                     check("fp_resp_valid", fp_resp_valid, 1);
                     check("fp_resp_id", fp_resp_id, h.fp_id);
                     check("fp_resp_data", fp_resp_data, h.fp_data);
                     void'(sb.pop_front());
                     m_idle = 1;
                     if (h.eff_err && m_cnt < (1 << CNT_W) - 1) m_cnt++;
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1;
   endtask

   task automatic send(input logic id, input logic [10:0] d, input logic [3:0] n, input logic e);
      bit hs = 0;
      if (id) begin b_valid = 1; b_data = d; b_n = n; b_err = e; end
      else    begin a_valid = 1; a_data = d; a_n = n; a_err = e; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (id ? b_ready : a_ready) begin hs = 1; break; end
      end
      check("send_timeout", hs, 1);
      @(posedge clk); #1;
      if (id) b_valid = 0; else a_valid = 0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (m_idle && sb.size() == 0) begin done = 1; break; end
      end
      check("drain_timeout", done, 1);
   endtask

   initial begin
      int cnt_tab[5] = '{1, 2, 3, 3, 3};
      bit got;

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_resp_code", resp_code, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_mismatch", resp_mismatch, 0);

      // Single A request
      send(0, 11'h5A3, 4'd0, 0);
      wait_idle();

      // n==15 guard: data intact, counter unchanged
      send(1, 11'h2C7, 4'd15, 1);
      wait_idle();
`ifdef HAMMING_SCHED_ERR_COUNT_EN
      check("cnt_n15", err_count, 0);
      // Saturating counter sequence
      for (int i = 0; i < 5; i++) begin
         send(0, 11'(i * 37 + 5), 4'd3, 1);
         wait_idle();
         check("cnt_seq", err_count, cnt_tab[i]);
      end
`endif

      // Reset while a request sits in COR: it must vanish
      send(0, 11'h1F0, 4'd2, 1);
      @(posedge clk); #1;
      rst_n = 0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1;
      @(negedge clk);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_resp_valid", resp_valid, 0);
      check("rst_mid_ready", {a_ready, b_ready}, 0);
      repeat (6) @(posedge clk);
      #1;

      // Error sweep on B
      for (int n = 0; n < 15; n++) begin
         send(1, 11'h2C7, 4'(n), 1);
         wait_idle();
      end

      // Contention: RR instance alternates, fixed-priority instance always takes A
      grants.delete();
      rec_grants = 1;
      a_data = 11'h111; a_n = 4'd5; a_err = 1;
      b_data = 11'h222; b_n = 4'd9; b_err = 0;
      a_valid = 1; b_valid = 1;
      got = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (grants.size() >= 4) begin got = 1; break; end
      end
      a_valid = 0; b_valid = 0;
      rec_grants = 0;
      check("contention_timeout", got, 1);
      wait_idle();
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check("rr_grant", grants[i], i % 2);

      // Backpressure: hold RESP for 10 cycles with requests pending
      resp_ready = 0;
      send(0, 11'h6B5, 4'd7, 1);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin got = 1; break; end
      end
      check("bp_resp_timeout", got, 1);
      @(posedge clk); #1;
      a_valid = 1; b_valid = 1; a_data = 11'h033; b_data = 11'h044; a_err = 0; b_err = 0;
      repeat (10) @(posedge clk);
      #1 resp_ready = 1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_idle_next", busy, 0);
      @(posedge clk); #1;
      a_valid = 0; b_valid = 0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
